// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - key event decoder state encodings and 100 Hz tick defaults
package key_evt_pkg;

    // Decoder states; the remaining 2-bit encoding is unused and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } key_state_e;

    // Default tick counts for a 100 Hz sample clock
    localparam int KEY_MIN_TICKS    = 2;    // 20 ms minimum valid press
    localparam int KEY_LONG_TICKS   = 100;  // 1 s hold for a long press
    localparam int KEY_REPEAT_TICKS = 20;   // 200 ms auto-repeat period

endpackage

// File: rtl/key_tick_cnt.sv
// rtl/key_tick_cnt.sv - CNT_W-bit tick counter with clear, enable and terminal compare
module key_tick_cnt #(
    parameter int CNT_W = 8,
    parameter int TERM  = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             at_term
);

    // at_term flags the last count before the terminal value is reached
    localparam logic [CNT_W-1:0] TERM_LAST = CNT_W'(TERM - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_term = (cnt_q == TERM_LAST);

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - debounced key to short/long/repeat pulses; KEY_REPEAT_EN enables auto-repeat
module key_event_decoder
    import key_evt_pkg::*;
#(
    parameter bit KEY_ACTIVE_LOW = 1'b1,
    parameter int MIN_TICKS      = KEY_MIN_TICKS,
    parameter int LONG_TICKS     = KEY_LONG_TICKS,
    parameter int REPEAT_TICKS   = KEY_REPEAT_TICKS,
    parameter int CNT_W          = 8
) (
    input  logic clk100hz,
    input  logic rst_n,
    input  logic key_in,
    output logic pressed,
    output logic short_pulse,
    output logic long_pulse,
    output logic rep_pulse
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_TICKS);

    key_state_e state_q;
    key_state_e state_d;

    logic act;
    logic act_q;
    logic act_d;

    logic short_q;
    logic short_d;
    logic long_q;
    logic long_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt;
    logic             cnt_term;

    assign act   = KEY_ACTIVE_LOW ? ~key_in : key_in;
    assign act_d = act;

    // Hold counter: number of active samples seen in the current press
    key_tick_cnt #(
        .CNT_W (CNT_W),
        .TERM  (LONG_TICKS)
    ) u_cnt (
        .clk     (clk100hz),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .cnt     (cnt),
        .at_term (cnt_term)
    );

`ifdef KEY_REPEAT_EN
    logic             rcnt_clr;
    logic             rcnt_en;
    logic [CNT_W-1:0] rcnt_val_unused;
    logic             rcnt_term;
    logic             rep_q;
    logic             rep_d;

    // Repeat counter: ticks since long press or since the last repeat pulse
    key_tick_cnt #(
        .CNT_W (CNT_W),
        .TERM  (REPEAT_TICKS)
    ) u_rcnt (
        .clk     (clk100hz),
        .rst_n   (rst_n),
        .clr     (rcnt_clr),
        .en      (rcnt_en),
        .cnt     (rcnt_val_unused),
        .at_term (rcnt_term)
    );
`endif

    // Next state, counter controls and pulse requests; release is checked first
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        short_d = 1'b0;
        long_d  = 1'b0;
`ifdef KEY_REPEAT_EN
        rcnt_clr = 1'b0;
        rcnt_en  = 1'b0;
        rep_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (act_q) begin
                    // Counter is zero in IDLE, so one increment loads 1
                    state_d = ST_PRESS;
                    cnt_en  = 1'b1;
                end
            end
            ST_PRESS: begin
                if (!act_q) begin
                    state_d = ST_IDLE;
                    short_d = (cnt >= MIN_C);
                    cnt_clr = 1'b1;
                end else if (cnt_term) begin
                    state_d = ST_HELD;
                    long_d  = 1'b1;
`ifdef KEY_REPEAT_EN
                    rcnt_clr = 1'b1;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_HELD: begin
                // Hold counter is frozen here, so an arbitrarily long hold never wraps
                if (!act_q) begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
`ifdef KEY_REPEAT_EN
                    rcnt_clr = 1'b1;
`endif
                end else begin
`ifdef KEY_REPEAT_EN
                    if (rcnt_term) begin
                        rep_d    = 1'b1;
                        rcnt_clr = 1'b1;
                    end else begin
                        rcnt_en = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
`ifdef KEY_REPEAT_EN
                rcnt_clr = 1'b1;
`endif
            end
        endcase
    end

    // State, sampled key level and registered pulses
    always_ff @(posedge clk100hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            act_q   <= 1'b0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            short_q <= short_d;
            long_q  <= long_d;
        end
    end

`ifdef KEY_REPEAT_EN
    // Registered repeat pulse
    always_ff @(posedge clk100hz or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign rep_pulse = rep_q;
`else
    assign rep_pulse = 1'b0;
`endif

    assign pressed     = act_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - directed self-checking bench for key_event_decoder
module tb_key_event_decoder;

    logic clk100hz;
    logic rst_n;
    logic key_in;
    logic pressed;
    logic short_pulse;
    logic long_pulse;
    logic rep_pulse;

    int checks;
    int errors;

    // Per-run pulse record
    int short_cnt;
    int short_edge;
    int long_cnt;
    int long_edge;
    int rep_cnt;
    int rep_edge [4];
    int multi_cnt;
    int pressed_cnt;
    int pressed_first;

    key_event_decoder #(
        .KEY_ACTIVE_LOW (1'b1),
        .MIN_TICKS      (2),
        .LONG_TICKS     (100),
        .REPEAT_TICKS   (20),
        .CNT_W          (8)
    ) dut (
        .clk100hz    (clk100hz),
        .rst_n       (rst_n),
        .key_in      (key_in),
        .pressed     (pressed),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .rep_pulse   (rep_pulse)
    );

    initial begin
        clk100hz = 1'b0;
        forever #5 clk100hz = ~clk100hz;
    end

    task automatic clear_rec();
        short_cnt     = 0;
        short_edge    = -1;
        long_cnt      = 0;
        long_edge     = -1;
        rep_cnt       = 0;
        for (int i = 0; i < 4; i++) rep_edge[i] = -1;
        multi_cnt     = 0;
        pressed_cnt   = 0;
        pressed_first = -1;
    endtask

    task automatic sample(input int e);
        int n;
        n = 0;
        if (short_pulse === 1'b1) begin
            short_cnt++;
            short_edge = e;
            n++;
        end
        if (long_pulse === 1'b1) begin
            long_cnt++;
            long_edge = e;
            n++;
        end
        if (rep_pulse === 1'b1) begin
            if (rep_cnt < 4) rep_edge[rep_cnt] = e;
            rep_cnt++;
            n++;
        end
        if (n > 1) multi_cnt++;
        if (pressed === 1'b1) begin
            if (pressed_first < 0) pressed_first = e;
            pressed_cnt++;
        end
    endtask

    // Key active on edges 0..n_low-1, then released; records pulses per edge index
    task automatic run_press(input int n_low, input int n_total);
        clear_rec();
        key_in = 1'b0;
        for (int e = 0; e < n_total; e++) begin
            @(posedge clk100hz);
            #1;
            if (e == n_low - 1) key_in = 1'b1;
            sample(e);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        key_in = 1'b0;
        repeat (3) @(posedge clk100hz);
        #1;
        checks++;
        if ({pressed, short_pulse, long_pulse, rep_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000",
                     {pressed, short_pulse, long_pulse, rep_pulse});
        end
        key_in = 1'b1;
        rst_n  = 1'b1;
        clear_rec();
        for (int e = 0; e < 10; e++) begin
            @(posedge clk100hz);
            #1;
            sample(e);
        end
        checks++;
        if (short_cnt + long_cnt + rep_cnt + pressed_cnt !== 0) begin
            errors++;
            $display("FAIL idle_after_reset got %0d events want 0",
                     short_cnt + long_cnt + rep_cnt + pressed_cnt);
        end
    endtask

    task automatic test_glitch();
        run_press(1, 8);
        checks++;
        if (short_cnt + long_cnt + rep_cnt !== 0) begin
            errors++;
            $display("FAIL glitch_pulses got %0d want 0", short_cnt + long_cnt + rep_cnt);
        end
        checks++;
        if (pressed_cnt !== 1 || pressed_first !== 0) begin
            errors++;
            $display("FAIL glitch_pressed got cnt %0d first %0d want cnt 1 first 0",
                     pressed_cnt, pressed_first);
        end
    endtask

    task automatic test_min_press();
        run_press(2, 8);
        checks++;
        if (short_cnt !== 1 || short_edge !== 3) begin
            errors++;
            $display("FAIL min_short got cnt %0d edge %0d want cnt 1 edge 3",
                     short_cnt, short_edge);
        end
    endtask

    task automatic test_short();
        run_press(30, 40);
        checks++;
        if (short_cnt !== 1 || short_edge !== 31) begin
            errors++;
            $display("FAIL short30 got cnt %0d edge %0d want cnt 1 edge 31",
                     short_cnt, short_edge);
        end
        checks++;
        if (long_cnt !== 0 || rep_cnt !== 0) begin
            errors++;
            $display("FAIL short30_nolong got long %0d rep %0d want 0 0", long_cnt, rep_cnt);
        end
        checks++;
        if (pressed_cnt !== 30) begin
            errors++;
            $display("FAIL short30_pressed got %0d want 30", pressed_cnt);
        end
    endtask

    task automatic test_long_boundary();
        run_press(99, 110);
        checks++;
        if (short_cnt !== 1 || short_edge !== 100 || long_cnt !== 0) begin
            errors++;
            $display("FAIL press99 got short %0d @%0d long %0d want short 1 @100 long 0",
                     short_cnt, short_edge, long_cnt);
        end
        run_press(100, 110);
        checks++;
        if (long_cnt !== 1 || long_edge !== 100) begin
            errors++;
            $display("FAIL press100_long got cnt %0d edge %0d want cnt 1 edge 100",
                     long_cnt, long_edge);
        end
        checks++;
        if (short_cnt !== 0) begin
            errors++;
            $display("FAIL press100_noshort got %0d want 0", short_cnt);
        end
    endtask

    task automatic test_repeat();
        run_press(150, 175);
        checks++;
        if (long_cnt !== 1 || long_edge !== 100 || short_cnt !== 0) begin
            errors++;
            $display("FAIL hold150_long got long %0d @%0d short %0d want long 1 @100 short 0",
                     long_cnt, long_edge, short_cnt);
        end
`ifdef KEY_REPEAT_EN
        checks++;
        if (rep_cnt !== 2 || rep_edge[0] !== 120 || rep_edge[1] !== 140) begin
            errors++;
            $display("FAIL hold150_rep got cnt %0d @%0d,%0d want cnt 2 @120,140",
                     rep_cnt, rep_edge[0], rep_edge[1]);
        end
`else
        checks++;
        if (rep_cnt !== 0) begin
            errors++;
            $display("FAIL hold150_rep got cnt %0d want 0", rep_cnt);
        end
`endif
        checks++;
        if (multi_cnt !== 0) begin
            errors++;
            $display("FAIL pulse_exclusive got %0d overlaps want 0", multi_cnt);
        end
    endtask

    task automatic test_reset_mid_hold();
        key_in = 1'b0;
        for (int e = 0; e <= 50; e++) begin
            @(posedge clk100hz);
            #1;
        end
        checks++;
        if (pressed !== 1'b1) begin
            errors++;
            $display("FAIL hold_pressed got %b want 1", pressed);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pressed, short_pulse, long_pulse, rep_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got %b want 0000",
                     {pressed, short_pulse, long_pulse, rep_pulse});
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk100hz);
            #1;
            checks++;
            if ({pressed, short_pulse, long_pulse, rep_pulse} !== 4'b0000) begin
                errors++;
                $display("FAIL in_reset_%0d got %b want 0000", c,
                         {pressed, short_pulse, long_pulse, rep_pulse});
            end
        end
        rst_n = 1'b1;
        clear_rec();
        for (int e = 0; e < 120; e++) begin
            @(posedge clk100hz);
            #1;
            sample(e);
        end
        checks++;
        if (long_cnt !== 1 || long_edge !== 100 || short_cnt !== 0 || rep_cnt !== 0) begin
            errors++;
            $display("FAIL post_reset_long got long %0d @%0d short %0d rep %0d want long 1 @100 short 0 rep 0",
                     long_cnt, long_edge, short_cnt, rep_cnt);
        end
        key_in = 1'b1;
        repeat (5) @(posedge clk100hz);
        #1;
    endtask

    task automatic test_back_to_back();
        run_press(5, 7);
        run_press(5, 9);
        checks++;
        if (short_cnt !== 1 || short_edge !== 6) begin
            errors++;
            $display("FAIL back_to_back got cnt %0d edge %0d want cnt 1 edge 6",
                     short_cnt, short_edge);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        key_in = 1'b1;
        clear_rec();
        test_reset();
        test_glitch();
        test_min_press();
        test_short();
        test_long_boundary();
        test_repeat();
        test_reset_mid_hold();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
